// File: rtl/pixel_compositor.sv
// Final video stage: re-aligns counter/background/sprite layers and syncs, resolves priority,
// applies a per-frame brightness fade. Fade logic present only with `PIXEL_COMPOSITOR_FADE_EN.
module pixel_compositor #(
    parameter int unsigned BG_LATENCY     = 4,
    parameter int unsigned SPRITE_LATENCY = 2,
    parameter logic [11:0] SPRITE_KEY     = 12'hF0F,
    parameter logic [11:0] BACKDROP       = 12'h000
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [11:0] counter_pixel_in,
    input  logic [11:0] bg_pixel_in,
    input  logic [11:0] sprite_pixel_in,
    input  logic        fade_out_in,
    input  logic        fade_in_in,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        fade_busy_out,
    output logic        fade_done_out
);

    localparam int unsigned SPR_DLY = BG_LATENCY - SPRITE_LATENCY;

    logic [11:0]           cnt_dly [BG_LATENCY];
    logic [BG_LATENCY-1:0] hs_dly;
    logic [BG_LATENCY-1:0] vs_dly;
    logic [BG_LATENCY-1:0] bl_dly;
    logic [11:0]           spr_al;
    logic [11:0]           mix;
    logic [11:0]           scaled;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < BG_LATENCY; i++) begin
                cnt_dly[i] <= '0;
            end
            hs_dly <= '1;
            vs_dly <= '1;
            bl_dly <= '1;
        end else begin
            cnt_dly[0] <= counter_pixel_in;
            hs_dly[0]  <= hsync_in;
            vs_dly[0]  <= vsync_in;
            bl_dly[0]  <= blank_in;
            for (int unsigned i = 1; i < BG_LATENCY; i++) begin
                cnt_dly[i] <= cnt_dly[i-1];
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
                bl_dly[i]  <= bl_dly[i-1];
            end
        end
    end

    generate
        if (SPR_DLY == 0) begin : g_spr_direct
            assign spr_al = sprite_pixel_in;
        end else begin : g_spr_delay
            logic [11:0] spr_dly [SPR_DLY];
            always_ff @(posedge pixel_clk_in or posedge rst_in) begin
                if (rst_in) begin
                    for (int unsigned i = 0; i < SPR_DLY; i++) begin
                        spr_dly[i] <= '0;
                    end
                end else begin
                    spr_dly[0] <= sprite_pixel_in;
                    for (int unsigned i = 1; i < SPR_DLY; i++) begin
                        spr_dly[i] <= spr_dly[i-1];
                    end
                end
            end
            assign spr_al = spr_dly[SPR_DLY-1];
        end
    endgenerate

    // bg_pixel_in is the slowest layer and arrives already aligned
    always_comb begin
        mix = BACKDROP;
        if (spr_al != SPRITE_KEY) begin
            mix = spr_al;
        end else if (bg_pixel_in != 12'h000) begin
            mix = bg_pixel_in;
        end else if (cnt_dly[BG_LATENCY-1] != 12'h000) begin
            mix = cnt_dly[BG_LATENCY-1];
        end
    end

`ifdef PIXEL_COMPOSITOR_FADE_EN
    typedef enum logic [1:0] {IDLE, FADE_OUT, DARK, FADE_IN} fade_state_t;

    fade_state_t state;
    logic [4:0]  level;
    logic        vsync_prev;
    logic        frame_tick;
    logic        unused_inputs;

    assign frame_tick    = vsync_prev & ~vsync_in;
    assign unused_inputs = ^{hcount_in, vcount_in};

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
        logic [7:0] p;
        p = 8'(c) * 8'(l);
        return 4'(p >> 4);
    endfunction

    // A request seen on a tick cycle only changes direction; stepping resumes next tick
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            level         <= 5'd16;
            vsync_prev    <= 1'b1;
            fade_busy_out <= 1'b0;
            fade_done_out <= 1'b0;
        end else begin
            vsync_prev    <= vsync_in;
            fade_done_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fade_out_in) begin
                        state         <= FADE_OUT;
                        fade_busy_out <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (fade_in_in && !fade_out_in) begin
                        state <= FADE_IN;
                    end else if (frame_tick) begin
                        level <= level - 5'd1;
                        if (level == 5'd1) begin
                            state         <= DARK;
                            fade_busy_out <= 1'b0;
                            fade_done_out <= 1'b1;
                        end
                    end
                end
                DARK: begin
                    if (fade_in_in && !fade_out_in) begin
                        state         <= FADE_IN;
                        fade_busy_out <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (fade_out_in) begin
                        state <= FADE_OUT;
                    end else if (frame_tick) begin
                        level <= level + 5'd1;
                        if (level == 5'd15) begin
                            state         <= IDLE;
                            fade_busy_out <= 1'b0;
                            fade_done_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign scaled = {scale(mix[11:8], level), scale(mix[7:4], level), scale(mix[3:0], level)};
`else
    logic unused_inputs;

    assign unused_inputs = ^{hcount_in, vcount_in, fade_out_in, fade_in_in};
    assign scaled        = mix;
    assign fade_busy_out = 1'b0;
    assign fade_done_out = 1'b0;
`endif

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            rgb_out   <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            blank_out <= 1'b1;
        end else begin
            rgb_out   <= bl_dly[BG_LATENCY-1] ? 12'h000 : scaled;
            hsync_out <= hs_dly[BG_LATENCY-1];
            vsync_out <= vs_dly[BG_LATENCY-1];
            blank_out <= bl_dly[BG_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor; fade expectations follow `PIXEL_COMPOSITOR_FADE_EN.
module tb_pixel_compositor;

    localparam int          BL  = 4;
    localparam int          SL  = 2;
    localparam logic [11:0] KEY = 12'hF0F;
`ifdef PIXEL_COMPOSITOR_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic        pixel_clk_in;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic [11:0] counter_pixel_in, bg_pixel_in, sprite_pixel_in;
    logic        fade_out_in, fade_in_in;
    logic [11:0] rgb_out;
    logic        hsync_out, vsync_out, blank_out;
    logic        fade_busy_out, fade_done_out;

    pixel_compositor #(
        .BG_LATENCY(BL),
        .SPRITE_LATENCY(SL),
        .SPRITE_KEY(KEY),
        .BACKDROP(12'h000)
    ) dut (
        .pixel_clk_in(pixel_clk_in),
        .rst_in(rst_in),
        .hcount_in(hcount_in),
        .vcount_in(vcount_in),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .blank_in(blank_in),
        .counter_pixel_in(counter_pixel_in),
        .bg_pixel_in(bg_pixel_in),
        .sprite_pixel_in(sprite_pixel_in),
        .fade_out_in(fade_out_in),
        .fade_in_in(fade_in_in),
        .rgb_out(rgb_out),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .blank_out(blank_out),
        .fade_busy_out(fade_busy_out),
        .fade_done_out(fade_done_out)
    );

    typedef struct {
        int          due;
        logic [14:0] v;
    } exp_t;

    exp_t        outq[$];
    exp_t        stq[$];
    logic [11:0] h_bg  [4096];
    logic [11:0] h_spr [4096];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          finished = 1'b0;
    logic        cur_busy = 1'b0;

    initial pixel_clk_in = 1'b0;
    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected grey channel for a full-white pixel at brightness level lvl
    function automatic logic [11:0] g(input int lvl);
        int n;
        n = FADE ? (15 * lvl) >> 4 : 15;
        return {3{4'(n)}};
    endfunction

    task automatic issue(input logic [11:0] cnt, input logic [11:0] bg, input logic [11:0] spr,
                         input logic hs, input logic vs, input logic bl,
                         input logic fo, input logic fi, input logic [11:0] exp_rgb,
                         input logic en, input logic eb, input logic ed);
        h_bg[cyc]        = bg;
        h_spr[cyc]       = spr;
        counter_pixel_in = cnt;
        hsync_in         = hs;
        vsync_in         = vs;
        blank_in         = bl;
        fade_out_in      = fo;
        fade_in_in       = fi;
        hcount_in        = 11'(cyc);
        vcount_in        = '0;
        sprite_pixel_in  = (cyc >= SL) ? h_spr[cyc-SL] : KEY;
        bg_pixel_in      = (cyc >= BL) ? h_bg[cyc-BL] : 12'h000;
        if (en) begin
            outq.push_back('{due: cyc + BL + 1, v: {exp_rgb, hs, vs, bl}});
            stq.push_back('{due: cyc + 1, v: {13'b0, eb, ed}});
        end
        @(posedge pixel_clk_in);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic en);
        issue(12'h000, 12'h000, KEY, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, en, cur_busy, 1'b0);
    endtask

    // 16-slot frame: tick at slot 1, blank on slots 0..3, optional request at slot 8
    task automatic frame(input logic [11:0] exp_pix, input logic b_tick, input logic d_tick,
                         input logic fo, input logic fi, input logic b_req);
        for (int s = 0; s < 16; s++) begin
            logic vs, bl, eb;
            vs = !(s == 1 || s == 2);
            bl = (s < 4);
            eb = (s == 0) ? cur_busy : ((s < 8) ? b_tick : b_req);
            issue(12'hFFF, 12'h000, KEY, 1'b1, vs, bl, (s == 8) & fo, (s == 8) & fi,
                  bl ? 12'h000 : exp_pix, 1'b1, eb, (s == 1) & d_tick);
        end
        cur_busy = b_req;
    endtask

    initial begin
        while (!finished) begin
            @(negedge pixel_clk_in or posedge rst_in);
            if (rst_in) begin
                #1;
                chk("rst_out", {rgb_out, hsync_out, vsync_out, blank_out, fade_busy_out, fade_done_out},
                    {12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
            end else begin
                while (outq.size() > 0 && outq[0].due <= cyc) begin
                    exp_t e;
                    e = outq.pop_front();
                    if (e.due < cyc) chk("pix_late", cyc, e.due);
                    else chk("pix {rgb,hs,vs,bl}", {rgb_out, hsync_out, vsync_out, blank_out}, e.v);
                end
                while (stq.size() > 0 && stq[0].due <= cyc) begin
                    exp_t e;
                    e = stq.pop_front();
                    if (e.due < cyc) chk("fade_late", cyc, e.due);
                    else chk("fade {busy,done}", {13'b0, fade_busy_out, fade_done_out}, e.v);
                end
            end
        end
        chk("drain", outq.size() + stq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            h_bg[i]  = 12'h000;
            h_spr[i] = KEY;
        end
        rst_in = 1'b0;
        idle(1'b0);
        rst_in = 1'b1;
        repeat (3) idle(1'b0);
        rst_in = 1'b0;

        // Alignment marker: B70 with hsync low must appear exactly BL+1 later, nowhere else
        repeat (8) idle(1'b1);
        issue(12'hB70, 12'h000, KEY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hB70, 1'b1, 1'b0, 1'b0);
        repeat (8) idle(1'b1);

        // Priority, back to back so each layer's skew is exercised
        issue(12'hB70, 12'h971, 12'h00F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F, 1'b1, 1'b0, 1'b0);
        issue(12'hB70, 12'h971, KEY,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h971, 1'b1, 1'b0, 1'b0);
        issue(12'hB70, 12'h000, KEY,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'hB70, 1'b1, 1'b0, 1'b0);
        issue(12'h000, 12'h000, KEY,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        issue(12'hB70, 12'h971, 12'h00F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        issue(12'h3C5, 12'h000, 12'h5A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5, 1'b1, 1'b0, 1'b0);
        repeat (6) idle(1'b1);

        // Simultaneous requests in IDLE, then full fade out
        frame(g(16), 1'b0, 1'b0, 1'b1, 1'b1, FADE);
        for (int k = 1; k <= 16; k++) begin
            frame(g(16 - k), FADE & (k < 16), FADE & (k == 16), 1'b0, 1'b0, FADE & (k < 16));
        end
        // fade_out in DARK is ignored; then fade in back to full
        frame(g(FADE ? 0 : 16), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(g(FADE ? 0 : 16), 1'b0, 1'b0, 1'b0, 1'b1, FADE);
        for (int k = 1; k <= 16; k++) begin
            frame(g(k), FADE & (k < 16), FADE & (k == 16), 1'b0, 1'b0, FADE & (k < 16));
        end

        // Reversal at L = 11
        frame(g(16), 1'b0, 1'b0, 1'b1, 1'b0, FADE);
        for (int k = 1; k <= 5; k++) begin
            frame(g(16 - k), FADE, 1'b0, 1'b0, k == 5, FADE);
        end
        for (int k = 1; k <= 5; k++) begin
            frame(g(11 + k), FADE & (k < 5), FADE & (k == 5), 1'b0, 1'b0, FADE & (k < 5));
        end

        // Reset mid fade-out at L = 7
        frame(g(16), 1'b0, 1'b0, 1'b1, 1'b0, FADE);
        for (int k = 1; k <= 9; k++) begin
            frame(g(16 - k), FADE, 1'b0, 1'b0, 1'b0, FADE);
        end
        repeat (6) issue(12'hFFF, 12'h000, KEY, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, g(7), 1'b1, cur_busy, 1'b0);
        #2;
        rst_in = 1'b1;
        outq.delete();
        stq.delete();
        @(posedge pixel_clk_in);
        #1;
        cyc++;
        cur_busy = 1'b0;
        repeat (2) idle(1'b0);
        rst_in = 1'b0;
        frame(g(16), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(g(16), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (BL + 4) idle(1'b0);
        finished = 1'b1;
    end

endmodule
